// File: rtl/mem_pkg.sv
// Shared types and sizes for the memory responder and its RAM.
package mem_pkg;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int RAM_DEPTH = 256;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_ILL   = 2'b11
  } mem_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } resp_state_t;
endpackage

// File: rtl/ram_256x16.sv
// Single-write-port RAM: synchronous write, registered read, no reset on contents.
module ram_256x16
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mem_responder.sv
// Bus responder: latches a core command, waits LATENCY cycles, commits, then
// pulses mem_ready. Boot-load writes always win the RAM write port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int               LATENCY   = 1,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] io_out,
  output logic              cmd_err
);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  resp_state_t       state;
  mem_cmd_t          cmd_q, cmd_in;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic              commit, is_mmio;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign cmd_in  = mem_cmd_t'(mem_cmd);
  assign is_mmio = (addr_q == MMIO_ADDR);
  // A load in the commit cycle owns the write port, so the commit waits.
  assign commit  = (state == S_WAIT) && (cnt == 4'd0) && !ld_valid;

  assign ram_we    = ld_valid || (commit && cmd_q == CMD_WRITE && !is_mmio);
  assign ram_waddr = ld_valid ? ld_addr : addr_q;
  assign ram_wdata = ld_valid ? ld_data : wdata_q;
  assign ram_re    = commit && cmd_q == CMD_READ;

  ram_256x16 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (addr_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cmd_q     <= CMD_NONE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      io_out    <= '0;
      cmd_err   <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      unique case (state)
        S_IDLE: begin
          // During the ready pulse the core still presents the finished command.
          if (!mem_ready) begin
            if (cmd_in == CMD_READ || cmd_in == CMD_WRITE) begin
              cmd_q   <= cmd_in;
              addr_q  <= mem_addr;
              wdata_q <= mem_wdata;
              cnt     <= CNT_INIT;
              state   <= S_WAIT;
            end else if (cmd_in == CMD_ILL) begin
              cmd_err <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (commit) begin
            if (cmd_q == CMD_WRITE && is_mmio) io_out <= wdata_q;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          mem_ready <= 1'b1;
          if (cmd_q == CMD_READ) mem_rdata <= is_mmio ? io_out : ram_rdata;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded bench: two responders (LATENCY 1 and 4) share clock, reset and load port.
module tb_mem_responder;
  logic        clk = 0, rst = 1;
  logic [1:0]  cmd1 = 0, cmd4 = 0;
  logic [7:0]  addr1 = 0, addr4 = 0;
  logic [15:0] wd1 = 0, wd4 = 0;
  logic [15:0] rd1, rd4, io1, io4;
  logic        rdy1, rdy4, err1, err4;
  logic        ld_valid = 0;
  logic [7:0]  ld_addr = 0;
  logic [15:0] ld_data = 0;

  int tests = 0, fails = 0, cyc = 0;

  typedef struct { logic [15:0] data; int lat; } exp_t;
  exp_t sb[$];
  logic [15:0] ram_m [2][256];
  logic [15:0] io_m [2];

  mem_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_cmd(cmd1), .mem_addr(addr1), .mem_wdata(wd1),
    .mem_rdata(rd1), .mem_ready(rdy1), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .io_out(io1), .cmd_err(err1));

  mem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .mem_cmd(cmd4), .mem_addr(addr4), .mem_wdata(wd4),
    .mem_rdata(rd4), .mem_ready(rdy4), .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_data(ld_data), .io_out(io4), .cmd_err(err4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1; ld_addr = a; ld_data = d;
    ram_m[0][a] = d; ram_m[1][a] = d;
    @(negedge clk);
    ld_valid = 0;
  endtask

  // One core transaction on the selected responder; optional load stall over the commit cycle.
  task automatic txn(input bit sel, input logic [1:0] c, input logic [7:0] a,
                     input logic [15:0] d, input bit stall, input string name);
    exp_t e;
    int acc, lat, lt;
    bit seen;
    lt = sel ? 4 : 1;
    @(negedge clk);
    e.data = 16'h0;
    if (c == 2'b01) e.data = (a == 8'hFF) ? io_m[sel] : ram_m[sel][a];
    else if (a == 8'hFF) io_m[sel] = d;
    else ram_m[sel][a] = d;
    e.lat = lt + 1 + (stall ? 3 : 0);
    sb.push_back(e);
    if (sel) begin cmd4 = c; addr4 = a; wd4 = d; end
    else begin cmd1 = c; addr1 = a; wd1 = d; end
    acc = cyc + 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (stall && cyc == acc + lt - 1) begin
        ld_valid = 1; ld_addr = 8'h80; ld_data = 16'hBEEF;
        ram_m[0][8'h80] = 16'hBEEF; ram_m[1][8'h80] = 16'hBEEF;
      end
      if (stall && cyc == acc + lt + 2) ld_valid = 0;
      if (c == 2'b10 && a == 8'hFF && !stall && cyc == acc + lt) begin
        tests++;
        if ((sel ? io4 : io1) !== d) begin
          fails++;
          $display("FAIL %s io_commit: got %h want %h", name, sel ? io4 : io1, d);
        end
      end
      if (sel ? rdy4 : rdy1) seen = 1;
    end
    ld_valid = 0;
    e = sb.pop_front();
    lat = cyc - acc;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s timeout: no ready, want latency %0d", name, e.lat);
    end else if (lat != e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
    end
    tests++;
    if (seen && (sel ? rd4 : rd1) !== e.data) begin
      fails++;
      $display("FAIL %s rdata: got %h want %h", name, sel ? rd4 : rd1, e.data);
    end
    @(posedge clk);
    #1;
    if (sel) cmd4 = 0; else cmd1 = 0;
    @(negedge clk);
    tests++;
    if ((sel ? rdy4 : rdy1) !== 1'b0) begin
      fails++;
      $display("FAIL %s ready_width: got %b want 0", name, sel ? rdy4 : rdy1);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    rst = 0;
    tests++;
    if ({rdy1, rdy4, err1, err4} !== 4'b0 || {rd1, rd4, io1, io4} !== 64'h0) begin
      fails++;
      $display("FAIL reset: rdy=%b%b err=%b%b rd=%h/%h io=%h/%h want all 0",
               rdy1, rdy4, err1, err4, rd1, rd4, io1, io4);
    end
  endtask

  task automatic test_preload_read;
    load(8'h07, 16'h1234);
    txn(0, 2'b01, 8'h07, 16'h0, 0, "preload_read");
  endtask

  task automatic test_write_read;
    txn(0, 2'b10, 8'h20, 16'd53, 0, "write_20");
    txn(0, 2'b01, 8'h20, 16'h0, 0, "read_20");
    tests++;
    if (io1 !== 16'h0) begin
      fails++;
      $display("FAIL io_hold_ram_write: got %h want 0000", io1);
    end
  endtask

  task automatic test_mmio;
    int bad;
    txn(0, 2'b10, 8'hFF, 16'd65505, 0, "mmio_write");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy1 !== 1'b0 || io1 !== 16'hFFE1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mmio_idle: %0d bad cycles, io=%h want FFE1 and no ready", bad, io1);
    end
    txn(0, 2'b01, 8'hFF, 16'h0, 0, "mmio_read");
  endtask

  task automatic test_latency4;
    txn(1, 2'b01, 8'h07, 16'h0, 0, "lat4_read");
    txn(1, 2'b01, 8'h07, 16'h0, 1, "lat4_stall");
  endtask

  task automatic test_illegal;
    int bad;
    @(negedge clk);
    cmd1 = 2'b11;
    @(negedge clk);
    cmd1 = 2'b00;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rdy1 !== 1'b0) bad++;
    end
    tests++;
    if (err1 !== 1'b1 || bad != 0) begin
      fails++;
      $display("FAIL illegal: cmd_err=%b want 1, ready cycles %0d want 0", err1, bad);
    end
    txn(0, 2'b01, 8'h07, 16'h0, 0, "after_illegal");
    tests++;
    if (err1 !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: got %b want 1", err1);
    end
  endtask

  task automatic test_back_to_back;
    txn(0, 2'b10, 8'h31, 16'hA5A5, 0, "b2b_write");
    txn(0, 2'b01, 8'h31, 16'h0, 0, "b2b_read");
    txn(0, 2'b01, 8'h20, 16'h0, 0, "b2b_read2");
  endtask

  task automatic test_reset_abort;
    int bad;
    @(negedge clk);
    cmd4 = 2'b10; addr4 = 8'hFF; wd4 = 16'd9062;
    @(negedge clk);
    cmd4 = 2'b00;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    io_m[0] = 16'h0; io_m[1] = 16'h0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy4 !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0 || io4 !== 16'h0 || err1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_abort: ready cycles %0d io=%h err1=%b want 0/0000/0", bad, io4, err1);
    end
    txn(1, 2'b01, 8'h07, 16'h0, 0, "ram_after_reset");
  endtask

  initial begin
    io_m[0] = 0; io_m[1] = 0;
    test_reset();
    test_preload_read();
    test_write_read();
    test_mmio();
    test_latency4();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
